// File: rtl/ring_dec_pkg.sv
// ring_dec_pkg: shared definitions for the ring counter decoder slice.
//   ring_state_t  - decoder FSM states (IDLE, ACQUIRE, LOCKED)
//   DEF_WIDTH     - default ring width
//   DEF_LOCK_CNT  - default number of in-sequence samples needed to lock
//   DEF_ERR_W     - default error counter width
package ring_dec_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 3;
    localparam int DEF_ERR_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_t;

endpackage

// File: rtl/ring_counter_decoder_onehot.sv
// ring_onehot_check: combinational one-hot legality check and binary encode.
//   pattern - WIDTH-bit input pattern
//   legal   - 1 when exactly one bit of pattern is set
//   idx     - position of the set bit (meaningful only when legal)
module ring_onehot_check
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         pattern,
    output logic                     legal,
    output logic [$clog2(WIDTH)-1:0] idx
);

    localparam int IW = $clog2(WIDTH);

    // Non-zero with no second set bit: clearing the lowest set bit leaves zero.
    assign legal = (pattern != '0) && ((pattern & (pattern - WIDTH'(1))) == '0);

    // OR-ing positions of every set bit is exact for a one-hot pattern.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pattern[i]) begin
                idx = idx | i[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ring_counter_decoder.sv
// ring_counter_decoder: receiving end of a one-hot ring-count interface.
// Samples ring_in on valid cycles, decodes the hot bit to a binary index,
// and tracks lock on a sequence that rotates left by one per sample.
//   clk         - rising-edge clock
//   clr         - synchronous active-high reset
//   ring_in     - sampled ring pattern (WIDTH bits)
//   valid_in    - ring_in is sampled only when 1
//   index       - binary position of the last legal hot bit
//   index_valid - one-cycle pulse, index updated from a legal sample
//   locked      - decoder is in LOCKED state
//   err_pulse   - one-cycle pulse on a violation while locked
//   err_count   - saturating count of err_pulse events
// Build option: define RING_DEC_HOLD_EN to accept a repeated (paused)
// pattern while locked instead of flagging it as a sequence error.
module ring_counter_decoder
    import ring_dec_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     valid_in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     index_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_count
);

    localparam int IW = $clog2(WIDTH);
    localparam int MW = $clog2(LOCK_CNT + 1);

    ring_state_t      state;
    logic [WIDTH-1:0] stored;
    logic [MW-1:0]    match_cnt;

    logic             legal;
    logic [IW-1:0]    dec_idx;
    logic [WIDTH-1:0] expected;
    logic [MW-1:0]    match_nxt;
    logic             hold_ok;

    ring_onehot_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .pattern (ring_in),
        .legal   (legal),
        .idx     (dec_idx)
    );

    assign expected  = {stored[WIDTH-2:0], stored[WIDTH-1]};
    assign match_nxt = match_cnt + MW'(1);

`ifdef RING_DEC_HOLD_EN
    assign hold_ok = (ring_in == stored);
`else
    assign hold_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            stored      <= '0;
            match_cnt   <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            index_valid <= 1'b0;
            err_pulse   <= 1'b0;
            if (valid_in) begin
                // Decoding is independent of the FSM state.
                if (legal) begin
                    index       <= dec_idx;
                    index_valid <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (legal) begin
                            stored    <= ring_in;
                            match_cnt <= MW'(1);
                            state     <= (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                            locked    <= (LOCK_CNT == 1);
                        end
                    end
                    ACQUIRE: begin
                        if (!legal) begin
                            state     <= IDLE;
                            match_cnt <= '0;
                        end else if (ring_in == expected) begin
                            stored    <= ring_in;
                            match_cnt <= match_nxt;
                            if (match_nxt == MW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            stored    <= ring_in;
                            match_cnt <= MW'(1);
                        end
                    end
                    LOCKED: begin
                        if (legal && (ring_in == expected || hold_ok)) begin
                            stored <= ring_in;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (legal) begin
                                stored    <= ring_in;
                                match_cnt <= MW'(1);
                                state     <= (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                                locked    <= (LOCK_CNT == 1);
                            end else begin
                                match_cnt <= '0;
                                state     <= IDLE;
                                locked    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_counter_decoder.sv
module tb_ring_counter_decoder;

    typedef struct {
        logic       clr;
        logic       v;
        logic [3:0] ring;
        logic [1:0] idx;
        logic       iv;
        logic       lk;
        logic       ep;
        logic [7:0] ec;
    } vec_t;

`ifdef RING_DEC_HOLD_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic       clk;
    logic       clr0, valid0;
    logic [3:0] ring0;
    logic [1:0] index0;
    logic       iv0, lk0, ep0;
    logic [7:0] ec0;

    logic       clr1, valid1;
    logic [3:0] ring1;
    logic [1:0] index1;
    logic       iv1, lk1, ep1;
    logic [1:0] ec1;

    int passed;
    int total;

    vec_t vecs[$];
    vec_t sb[$];

    ring_counter_decoder #(
        .WIDTH    (4),
        .LOCK_CNT (3),
        .ERR_W    (8)
    ) dut0 (
        .clk         (clk),
        .clr         (clr0),
        .ring_in     (ring0),
        .valid_in    (valid0),
        .index       (index0),
        .index_valid (iv0),
        .locked      (lk0),
        .err_pulse   (ep0),
        .err_count   (ec0)
    );

    ring_counter_decoder #(
        .WIDTH    (4),
        .LOCK_CNT (1),
        .ERR_W    (2)
    ) dut1 (
        .clk         (clk),
        .clr         (clr1),
        .ring_in     (ring1),
        .valid_in    (valid1),
        .index       (index1),
        .index_valid (iv1),
        .locked      (lk1),
        .err_pulse   (ep1),
        .err_count   (ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic c, input logic v, input logic [3:0] r,
                                input logic [1:0] i, input logic iv, input logic lk,
                                input logic ep, input int ec);
        vec_t t;
        t.clr = c; t.v = v; t.ring = r; t.idx = i;
        t.iv = iv; t.lk = lk; t.ep = ep; t.ec = 8'(ec);
        vecs.push_back(t);
    endfunction

    task automatic step1(input logic c, input logic v, input logic [3:0] r,
                         input logic [1:0] i, input logic iv, input logic lk,
                         input logic ep, input logic [1:0] ec, input string tag);
        @(negedge clk);
        clr1 = c; valid1 = v; ring1 = r;
        @(posedge clk);
        #1;
        chk({tag, ".index"}, 32'(index1), 32'(i));
        chk({tag, ".index_valid"}, 32'(iv1), 32'(iv));
        chk({tag, ".locked"}, 32'(lk1), 32'(lk));
        chk({tag, ".err_pulse"}, 32'(ep1), 32'(ep));
        chk({tag, ".err_count"}, 32'(ec1), 32'(ec));
    endtask

    initial begin
        vec_t e;
        passed = 0;
        total  = 0;
        clr0 = 1'b1; valid0 = 1'b0; ring0 = '0;
        clr1 = 1'b1; valid1 = 1'b0; ring1 = '0;

        //   clr v  ring     idx iv lk ep ec
        add(1, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0001, 0, 1, 0, 0, 0);
        add(0, 1, 4'b0010, 1, 1, 0, 0, 0);
        add(0, 1, 4'b0100, 2, 1, 1, 0, 0);
        add(0, 1, 4'b1000, 3, 1, 1, 0, 0);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 0);   // wrap is in sequence
        add(0, 1, 4'b0010, 1, 1, 1, 0, 0);
        add(0, 1, 4'b1000, 3, 1, 0, 1, 1);   // skip -> ACQUIRE
        add(0, 1, 4'b0001, 0, 1, 0, 0, 1);
        add(0, 1, 4'b0010, 1, 1, 1, 0, 1);
        add(0, 1, 4'b0110, 1, 0, 0, 1, 2);   // multi-hot -> IDLE, index held
        add(0, 1, 4'b0000, 1, 0, 0, 0, 2);   // all-zero in IDLE: silent
        add(0, 1, 4'b0100, 2, 1, 0, 0, 2);
        add(0, 1, 4'b1000, 3, 1, 0, 0, 2);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 2);
        add(0, 0, 4'b1111, 0, 0, 1, 0, 2);   // valid low: garbage ignored
        add(0, 0, 4'b0000, 0, 0, 1, 0, 2);
        add(0, 0, 4'b0110, 0, 0, 1, 0, 2);
        add(0, 0, 4'b1000, 0, 0, 1, 0, 2);
        add(0, 0, 4'b0101, 0, 0, 1, 0, 2);
        add(0, 1, 4'b0010, 1, 1, 1, 0, 2);
        add(0, 1, 4'b0100, 2, 1, 1, 0, 2);
        add(0, 1, 4'b0100, 2, 1, H, 1 - H, 3 - H);   // repeated pattern
        add(0, 1, 4'b1000, 3, 1, H, 0, 3 - H);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 3 - H);
        add(0, 1, 4'b0100, 2, 1, 0, 1, 4 - H);
        add(0, 1, 4'b1000, 3, 1, 0, 0, 4 - H);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 4 - H);
        add(0, 1, 4'b0100, 2, 1, 0, 1, 5 - H);
        add(0, 1, 4'b1000, 3, 1, 0, 0, 5 - H);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 5 - H);
`ifdef RING_DEC_HOLD_EN
        add(0, 1, 4'b0100, 2, 1, 0, 1, 5);
        add(0, 1, 4'b1000, 3, 1, 0, 0, 5);
        add(0, 1, 4'b0001, 0, 1, 1, 0, 5);
`endif
        add(1, 1, 4'b0010, 0, 0, 0, 0, 0);   // clr wins over a valid sample
        add(0, 1, 4'b0100, 2, 1, 0, 0, 0);   // stored cleared: no lock

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            clr0 = vecs[n].clr; valid0 = vecs[n].v; ring0 = vecs[n].ring;
            sb.push_back(vecs[n]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d.scoreboard_empty", n), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d.index", n), 32'(index0), 32'(e.idx));
                chk($sformatf("v%0d.index_valid", n), 32'(iv0), 32'(e.iv));
                chk($sformatf("v%0d.locked", n), 32'(lk0), 32'(e.lk));
                chk($sformatf("v%0d.err_pulse", n), 32'(ep0), 32'(e.ep));
                chk($sformatf("v%0d.err_count", n), 32'(ec0), 32'(e.ec));
            end
        end

        // LOCK_CNT=1 instance: immediate lock, errors keep it locked,
        // 2-bit error counter saturates at 3.
        step1(1, 0, 4'b0000, 0, 0, 0, 0, 0, "l1_reset");
        step1(0, 1, 4'b0001, 0, 1, 1, 0, 0, "l1_lock");
        step1(0, 1, 4'b0100, 2, 1, 1, 1, 1, "l1_err1");
        step1(0, 1, 4'b0001, 0, 1, 1, 1, 2, "l1_err2");
        step1(0, 1, 4'b0100, 2, 1, 1, 1, 3, "l1_err3");
        step1(0, 1, 4'b0001, 0, 1, 1, 1, 3, "l1_sat");
        step1(0, 1, 4'b0010, 1, 1, 1, 0, 3, "l1_ok");
        step1(0, 1, 4'b0000, 1, 0, 0, 1, 3, "l1_zero");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_counter_decoder.md
Name: ring_counter_decoder

Overview:
- Receiving end of the one-hot ring-count interface. Samples a WIDTH-bit ring pattern each valid cycle and decodes it to a binary index.
- Checks that the pattern is exactly one-hot and advances by one left rotation per valid sample.
- Provides lock status, an error pulse and an error counter to downstream logic and benches that consume ring counter outputs.

Parameters:
- WIDTH, 4, ring width in bits; must be >= 2.
- LOCK_CNT, 3, consecutive legal, correctly rotated samples required to lock; must be >= 1.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- ring_in  in  WIDTH  sampled ring pattern.
- valid_in  in  1  ring_in is sampled only when 1.
- index  out  $clog2(WIDTH)  binary position of the hot bit.
- index_valid  out  1  one-cycle pulse: index updated from a legal sample.
- locked  out  1  decoder is in LOCKED state.
- err_pulse  out  1  one-cycle pulse on a sequence/one-hot violation while locked.
- err_count  out  ERR_W  saturating count of err_pulse events.

Behaviour:
- Interface rules: one clock (clk); reset clr is synchronous, active-high.
- Reset: all outputs read 0 after the reset edge: index, index_valid, locked, err_pulse, err_count. State goes to IDLE, stored pattern is 0, match_cnt is 0.
- Reset mid-operation: clr overrides all other inputs on that edge.
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N, so latency is 1 cycle.
- valid_in=0: no state change; index_valid and err_pulse are 0; index and err_count hold.
- Legality: popcount(ring_in)==1.
- Expected pattern: rotate-left of stored. Bit i moves to i+1, and bit WIDTH-1 wraps to bit 0 (e.g. 1000 -> 0001).
- Decoding: any legal sample sets index to the hot-bit position and sets index_valid=1 for one cycle. This applies in every state.
- An illegal sample never changes index.
- FSM state IDLE:
  - Legal sample: store it, match_cnt=1; go to LOCKED if LOCK_CNT==1, else to ACQUIRE.
  - Illegal sample: stay in IDLE, no error.
- FSM state ACQUIRE:
  - Legal and equal to expected: store it, match_cnt+1; go to LOCKED when match_cnt reaches LOCK_CNT.
  - Legal but not expected: store it, match_cnt=1, stay in ACQUIRE.
  - Illegal sample: go to IDLE, match_cnt=0, no error.
- FSM state LOCKED:
  - Legal and equal to expected: store it, stay in LOCKED.
  - Any other sample: err_pulse=1 and err_count increments.
  - After an error with a legal sample: store it, match_cnt=1, go to ACQUIRE (or stay in LOCKED if LOCK_CNT==1).
  - After an error with an illegal sample: go to IDLE.
- locked=1 exactly while state==LOCKED; it updates on the same edge as the state.
- err_count saturates at 2^ERR_W-1 and does not wrap.
- All-zero and multi-hot patterns are both illegal.

Optional Feature:
- Macro: RING_DEC_HOLD_EN.
- Defined: while in LOCKED, a valid sample equal to stored (counter paused) is accepted. It raises no error, stays in LOCKED, and still produces index_valid.
- Not defined: the same sample is a sequence violation and produces err_pulse.

Decomposition:
- Package ring_dec_pkg holds the state enum (IDLE, ACQUIRE, LOCKED) and the default constants WIDTH, LOCK_CNT, ERR_W.
- One sub-module, ring_onehot_check: combinational. Inputs are the pattern; outputs are legal and the binary index. The top module instantiates it once for ring_in.

Test Plan:
- Reset, then valid samples 0001,0010,0100 with LOCK_CNT=3 -> index 0,1,2 with index_valid each cycle; locked=1 after the third edge.
- While locked, continue with 1000,0001 -> index 3,0; no err_pulse (wrap-around is legal).
- While locked on 0010, feed 1000 -> err_pulse=1 for one cycle, err_count=1, locked=0, state ACQUIRE, index=3.
- While locked, feed 0110 -> err_pulse=1, err_count increments, state IDLE, index unchanged. Then feed 0000 -> no error and no index_valid.
- Hold valid_in=0 for 5 cycles while locked with garbage on ring_in -> no output change.
- With RING_DEC_HOLD_EN, repeat 0100 twice -> no error. Without the macro -> err_pulse on the repeated sample.
- Assert clr while locked with err_count=5 -> all outputs 0 on the next edge.
